// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
//   op_t      : 3-bit command code carried on the op port
//   OP_*      : command code values
//   state_t   : command FSM state (ST_IDLE, ST_CLEAR)
package regfile_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_WRITE  = 3'b000;
  localparam op_t OP_SWAP   = 3'b001;
  localparam op_t OP_BSET   = 3'b010;
  localparam op_t OP_BCLR   = 3'b011;
  localparam op_t OP_BTOG   = 3'b100;
  localparam op_t OP_CLRALL = 3'b101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // True for the single-bit manipulation commands.
  function automatic logic is_bitop(input op_t op);
    return (op == OP_BSET) || (op == OP_BCLR) || (op == OP_BTOG);
  endfunction

endpackage

// File: rtl/regfile_bitop.sv
// Combinational single-bit manipulation of one word (BSET/BCLR/BTOG).
//   word    : input word
//   bit_pos : bit index to operate on
//   op      : command code; non-bit commands pass the word through unchanged
//   result  : modified word
//   illegal : bit command with bit_pos >= DATA_W (result is then the input word)
module regfile_bitop
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned POS_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [POS_W-1:0]  bit_pos,
  input  op_t               op,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  logic              pos_ok;
  logic [DATA_W-1:0] mask;

  // Widened compare: POS_W bits can encode positions past a non-power-of-2 width.
  assign pos_ok = 32'(bit_pos) < DATA_W;
  assign mask   = DATA_W'(1) << bit_pos;

  always_comb begin
    result  = word;
    illegal = 1'b0;
    if (is_bitop(op)) begin
      if (!pos_ok) begin
        illegal = 1'b1;
      end else begin
        case (op)
          OP_BSET: result = word | mask;
          OP_BCLR: result = word & ~mask;
          OP_BTOG: result = word ^ mask;
          default: result = word;
        endcase
      end
    end
  end

endmodule

// File: rtl/param_regfile.sv
// Parametrised general-purpose register file with a command-driven write port.
//   clk, rst                 : clock, asynchronous active-low reset
//   op_valid/op_ready        : command handshake (accepted when both high)
//   op, wr_addr, src_addr,
//   data_in, bit_pos         : command code and operands
//   read_addr_0/1            : read addresses
//   read_data_0/1            : combinational read data (no write bypass)
//   busy                     : CLRALL in progress
//   err                      : one-cycle pulse after a rejected command
module param_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned POS_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  op_t               op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [POS_W-1:0]  bit_pos,
  input  logic [ADDR_W-1:0] read_addr_0,
  input  logic [ADDR_W-1:0] read_addr_1,
  output logic [DATA_W-1:0] read_data_0,
  output logic [DATA_W-1:0] read_data_1,
  output logic              busy,
  output logic              err
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];

  logic                accept;
  logic                wr_ok;
  logic                src_ok;
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   src_word;
  logic [DATA_W-1:0]   bit_word;
  logic                bit_illegal;

  // Handshake status comes straight from the state flop; no path from op_valid.
  assign op_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_CLEAR);
  assign err      = err_q;
  assign accept   = op_valid && op_ready;

  // Address range checks matter only when DEPTH is not a power of two.
  assign wr_ok    = 32'(wr_addr) < DEPTH;
  assign src_ok   = 32'(src_addr) < DEPTH;
  assign wr_word  = wr_ok  ? regs_q[wr_addr]  : '0;
  assign src_word = src_ok ? regs_q[src_addr] : '0;

  // Reads see the array as it is now; a same-cycle write shows after the edge.
  assign read_data_0 = (32'(read_addr_0) < DEPTH) ? regs_q[read_addr_0] : '0;
  assign read_data_1 = (32'(read_addr_1) < DEPTH) ? regs_q[read_addr_1] : '0;

  regfile_bitop #(
    .DATA_W (DATA_W),
    .POS_W  (POS_W)
  ) u_bitop (
    .word    (wr_word),
    .bit_pos (bit_pos),
    .op      (op),
    .result  (bit_word),
    .illegal (bit_illegal)
  );

  // Next-state, array update and error decode.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    err_d     = 1'b0;
    regs_d    = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_WRITE: begin
              if (wr_ok) regs_d[wr_addr] = data_in;
              else       err_d = 1'b1;
            end
            OP_SWAP: begin
              // Both sides read from regs_q, so wr_addr == src_addr is a no-op.
              if (wr_ok && src_ok) begin
                regs_d[wr_addr]  = src_word;
                regs_d[src_addr] = wr_word;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_BSET, OP_BCLR, OP_BTOG: begin
              if (wr_ok && !bit_illegal) regs_d[wr_addr] = bit_word;
              else                       err_d = 1'b1;
            end
            OP_CLRALL: begin
              state_d   = ST_CLEAR;
              clr_idx_d = '0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_CLEAR: begin
        // One register per edge, ascending; commands are ignored meanwhile.
        regs_d[clr_idx_q] = '0;
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // State, counter, error pulse and array registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      err_q     <= err_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_param_regfile.sv
// Self-checking bench for param_regfile: a 16x8 instance driven through a
// scoreboard of expected register contents, plus a 12x6 instance for the
// out-of-range bit position and address rejection cases.
module tb_param_regfile;
  import regfile_pkg::*;

  localparam int unsigned DW  = 16;
  localparam int unsigned DP  = 8;
  localparam int unsigned AW  = 3;
  localparam int unsigned PW  = 4;
  localparam int unsigned SDW = 12;
  localparam int unsigned SDP = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          op_valid;
  logic          op_ready;
  op_t           op;
  logic [AW-1:0] wr_addr, src_addr, read_addr_0, read_addr_1;
  logic [DW-1:0] data_in, read_data_0, read_data_1;
  logic [PW-1:0] bit_pos;
  logic          busy, err;

  logic           s_valid, s_ready, s_busy, s_err;
  op_t            s_op;
  logic [2:0]     s_wr, s_src, s_rd0, s_rd1;
  logic [SDW-1:0] s_din, s_dout0, s_dout1;
  logic [3:0]     s_pos;

  param_regfile #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .wr_addr(wr_addr), .src_addr(src_addr), .data_in(data_in), .bit_pos(bit_pos),
    .read_addr_0(read_addr_0), .read_addr_1(read_addr_1),
    .read_data_0(read_data_0), .read_data_1(read_data_1), .busy(busy), .err(err)
  );

  param_regfile #(.DATA_W(SDW), .DEPTH(SDP)) dut_small (
    .clk(clk), .rst(rst), .op_valid(s_valid), .op_ready(s_ready), .op(s_op),
    .wr_addr(s_wr), .src_addr(s_src), .data_in(s_din), .bit_pos(s_pos),
    .read_addr_0(s_rd0), .read_addr_1(s_rd1),
    .read_data_0(s_dout0), .read_data_1(s_dout1), .busy(s_busy), .err(s_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    int unsigned addr;
    logic [15:0] exp;
  } sb_t;

  sb_t         sbq[$];
  logic [15:0] mdl [DP];

  task automatic push(input string tag, input int unsigned a);
    sb_t e;
    e.tag  = tag;
    e.addr = a;
    e.exp  = mdl[a];
    sbq.push_back(e);
  endtask

  task automatic push_all(input string tag);
    for (int i = 0; i < int'(DP); i++) push($sformatf("%s_r%0d", tag, i), i);
  endtask

  // Pop each expectation and compare it on alternating read ports.
  task automatic drain();
    sb_t e;
    bit  port = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (!port) begin
        read_addr_0 = AW'(e.addr);
        #1 chk(e.tag, 32'(read_data_0), 32'(e.exp));
      end else begin
        read_addr_1 = AW'(e.addr);
        #1 chk(e.tag, 32'(read_data_1), 32'(e.exp));
      end
      port = ~port;
      @(negedge clk);
    end
  endtask

  // Present one single-cycle command, wait for acceptance, update the model.
  task automatic send(input op_t o, input int unsigned wa, input int unsigned sa,
                      input logic [15:0] d, input int unsigned p);
    int          n;
    logic [15:0] t;
    n = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    wr_addr  = AW'(wa);
    src_addr = AW'(sa);
    data_in  = d;
    bit_pos  = PW'(p);
    while (!op_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n == 64) chk("ready_timeout", 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("err_quiet", 32'(err), 32'd0);
    case (o)
      OP_WRITE: mdl[wa] = d;
      OP_SWAP: begin
        t       = mdl[wa];
        mdl[wa] = mdl[sa];
        mdl[sa] = t;
      end
      OP_BSET: mdl[wa][p] = 1'b1;
      OP_BCLR: mdl[wa][p] = 1'b0;
      OP_BTOG: mdl[wa][p] = ~mdl[wa][p];
      default: ;
    endcase
  endtask

  function automatic logic [15:0] fillv(input int i);
    return 16'(16'h0101 + i * 16'h1111);
  endfunction

  task automatic fill_all();
    for (int i = 0; i < int'(DP); i++) send(OP_WRITE, i, 0, fillv(i), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lowcnt;
    op_valid = 1'b0; op = OP_WRITE; wr_addr = '0; src_addr = '0; data_in = '0;
    bit_pos = '0; read_addr_0 = '0; read_addr_1 = '0;
    s_valid = 1'b0; s_op = OP_WRITE; s_wr = '0; s_src = '0; s_din = '0;
    s_pos = '0; s_rd0 = '0; s_rd1 = '0;
    for (int i = 0; i < int'(DP); i++) mdl[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_err",   32'(err),      32'd0);
    rst = 1'b1;
    push_all("rst");
    drain();

    // Back-to-back writes
    send(OP_WRITE, 2, 0, 16'h1234, 0);
    send(OP_WRITE, 5, 0, 16'h5678, 0);
    push("wr_r2", 2); push("wr_r5", 5);
    drain();

    // Swap, and self-swap
    send(OP_SWAP, 2, 5, 16'h0, 0);
    push("swap_r2", 2); push("swap_r5", 5);
    send(OP_WRITE, 3, 0, 16'h0BAD, 0);
    send(OP_SWAP, 3, 3, 16'h0, 0);
    push("selfswap_r3", 3);
    drain();

    // Bit operations on R0
    send(OP_BSET, 0, 0, 16'h0, 15); push("bset15", 0); drain();
    send(OP_BTOG, 0, 0, 16'h0, 0);  push("btog0",  0); drain();
    send(OP_BCLR, 0, 0, 16'h0, 15); push("bclr15", 0); drain();

    // CLRALL with a WRITE held during the clear
    fill_all();
    @(negedge clk);
    op_valid = 1'b1;
    op       = OP_CLRALL;
    @(negedge clk);
    op       = OP_WRITE;
    wr_addr  = 3'd4;
    data_in  = 16'hBEEF;
    lowcnt   = 0;
    while (!op_ready && lowcnt < 64) begin
      chk("clr_busy", 32'(busy), 32'd1);
      if (lowcnt >= 1) begin
        read_addr_0 = AW'(lowcnt - 1);
        #1 chk($sformatf("clr_done_r%0d", lowcnt - 1), 32'(read_data_0), 32'd0);
      end
      if (lowcnt < int'(DP)) begin
        read_addr_1 = AW'(lowcnt);
        #1 chk($sformatf("clr_pend_r%0d", lowcnt), 32'(read_data_1), 32'(mdl[lowcnt]));
      end
      lowcnt++;
      @(negedge clk);
    end
    chk("clr_ready_low_cycles", 32'(lowcnt), 32'(DP));
    chk("clr_busy_end", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(DP); i++) mdl[i] = '0;
    mdl[4] = 16'hBEEF;
    push_all("postclr");
    drain();

    // Reset asserted three edges into a clear
    fill_all();
    @(negedge clk);
    op_valid = 1'b1;
    op       = OP_CLRALL;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    read_addr_0 = 3'd6;
    read_addr_1 = 3'd7;
    #1;
    chk("midrst_ready", 32'(op_ready), 32'd1);
    chk("midrst_busy",  32'(busy),     32'd0);
    chk("midrst_r6",    32'(read_data_0), 32'd0);
    chk("midrst_r7",    32'(read_data_1), 32'd0);
    for (int i = 0; i < int'(DP); i++) mdl[i] = '0;
    push_all("midrst");
    drain();
    @(negedge clk);
    rst = 1'b1;

    // Read of a register being written in the same cycle
    send(OP_WRITE, 2, 0, 16'h1111, 0);
    @(negedge clk);
    op_valid    = 1'b1;
    op          = OP_WRITE;
    wr_addr     = 3'd2;
    data_in     = 16'h2345;
    read_addr_0 = 3'd2;
    #1 chk("rdw_old", 32'(read_data_0), 32'h1111);
    @(posedge clk);
    #1 chk("rdw_new", 32'(read_data_0), 32'h2345);
    mdl[2] = 16'h2345;

    // Reserved codes: err pulse, array untouched
    @(negedge clk);
    op      = 3'b110;
    wr_addr = 3'd1;
    data_in = 16'hFFFF;
    @(posedge clk);
    #1 chk("rsvd6_err", 32'(err), 32'd1);
    @(negedge clk);
    op = 3'b111;
    @(posedge clk);
    #1 chk("rsvd7_err", 32'(err), 32'd1);
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk);
    #1 chk("rsvd_err_drop", 32'(err), 32'd0);
    push_all("rsvd");
    drain();

    // 12-bit x 6-entry instance: range rejections
    @(negedge clk);
    s_valid = 1'b1; s_op = OP_WRITE; s_wr = 3'd5; s_din = 12'hABC;
    s_rd0 = 3'd5; s_rd1 = 3'd0;
    @(posedge clk);
    #1 chk("s_wr_err", 32'(s_err), 32'd0);
    chk("s_wr_r5", 32'(s_dout0), 32'hABC);
    @(negedge clk);
    s_op = OP_BSET; s_pos = 4'd15;
    @(posedge clk);
    #1 chk("s_pos15_err", 32'(s_err), 32'd1);
    chk("s_pos15_r5", 32'(s_dout0), 32'hABC);
    @(negedge clk);
    s_op = OP_BTOG; s_pos = 4'd11;
    @(posedge clk);
    #1 chk("s_btog11_err", 32'(s_err), 32'd0);
    chk("s_btog11_r5", 32'(s_dout0), 32'h2BC);
    @(negedge clk);
    s_op = OP_WRITE; s_wr = 3'd6; s_din = 12'hFFF;
    @(posedge clk);
    #1 chk("s_addr6_err", 32'(s_err), 32'd1);
    chk("s_addr6_r5", 32'(s_dout0), 32'h2BC);
    @(negedge clk);
    s_op = OP_SWAP; s_wr = 3'd5; s_src = 3'd7;
    @(posedge clk);
    #1 chk("s_src7_err", 32'(s_err), 32'd1);
    chk("s_src7_r5", 32'(s_dout0), 32'h2BC);
    @(negedge clk);
    s_src = 3'd0;
    @(posedge clk);
    #1 chk("s_swap_err", 32'(s_err), 32'd0);
    chk("s_swap_r5", 32'(s_dout0), 32'h000);
    chk("s_swap_r0", 32'(s_dout1), 32'h2BC);
    @(negedge clk);
    s_valid = 1'b0;
    @(posedge clk);
    #1 chk("s_err_idle", 32'(s_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
